// File: rtl/vote_ctrl.sv
// Four-voter ballot collector: opens a session on start, accepts first ballots
// until all voters respond or the COLLECT timer expires, then posts a one-hot verdict.
module vote_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] vote_valid,
   input  logic [3:0] vote_val,
   output logic       busy,
   output logic [3:0] voted,
   output logic [2:0] yes_cnt,
   output logic [3:1] result,
   output logic       done,
   output logic       timed_out
);

   typedef enum logic [1:0] {IDLE, COLLECT, DECIDE} state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t     state_q;
   logic [7:0] timer_q;
   logic [3:0] voted_q;
   logic [3:0] accept;
   logic [3:0] voted_d;
   logic [2:0] yes_q;
   logic [2:0] yes_d;
   logic [3:1] result_q;
   logic       done_q;
   logic       timed_out_q;

   // Post-update view of this edge's ballots; only voters not yet recorded count.
   always_comb begin
      accept  = vote_valid & ~voted_q;
      voted_d = voted_q | accept;
      yes_d   = yes_q;
      for (int unsigned i = 0; i < 4; i++) begin
         yes_d = yes_d + {2'b00, accept[i] & vote_val[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         voted_q     <= '0;
         yes_q       <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= COLLECT;
                  timer_q     <= '0;
                  voted_q     <= '0;
                  yes_q       <= '0;
                  result_q    <= '0;
                  timed_out_q <= 1'b0;
               end
            end
            COLLECT: begin
               timer_q <= timer_q + 8'd1;
               voted_q <= voted_d;
               yes_q   <= yes_d;
               if ((voted_d == 4'b1111) || (timer_q == TLAST)) begin
                  state_q     <= DECIDE;
                  timed_out_q <= (voted_d != 4'b1111);
               end
            end
            DECIDE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               if (yes_q >= 3'd3)      result_q <= 3'b100;
               else if (yes_q == 3'd2) result_q <= 3'b010;
               else                    result_q <= 3'b001;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign voted     = voted_q;
   assign yes_cnt   = yes_q;
   assign result    = result_q;
   assign done      = done_q;
   assign timed_out = timed_out_q;

endmodule

// File: tb/tb_vote_ctrl.sv
// Directed bench for vote_ctrl: per-cycle vector table on a TIMEOUT=16 instance,
// plus hand-written timeout sequences on TIMEOUT=16 and TIMEOUT=4 instances.
module tb_vote_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] vv = '0;
   logic [3:0] vval = '0;

   logic       busy16, done16, to16, busy4, done4, to4;
   logic [3:0] voted16, voted4;
   logic [2:0] yes16, yes4;
   logic [3:1] res16, res4;

   int unsigned pass_cnt = 0;
   int unsigned total    = 0;

   always #5 clk = ~clk;

   vote_ctrl #(.TIMEOUT(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .vote_valid(vv), .vote_val(vval),
      .busy(busy16), .voted(voted16), .yes_cnt(yes16), .result(res16),
      .done(done16), .timed_out(to16)
   );

   vote_ctrl #(.TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .vote_valid(vv), .vote_val(vval),
      .busy(busy4), .voted(voted4), .yes_cnt(yes4), .result(res4),
      .done(done4), .timed_out(to4)
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic [3:0]  vv;
      logic [3:0]  vval;
      logic [12:0] exp;
   } vec_t;

   // Expected-output packing: {busy, voted, yes_cnt, result, done, timed_out}
   function automatic logic [12:0] o(input logic b, input logic [3:0] v, input logic [2:0] y,
                                     input logic [2:0] r, input logic d, input logic t);
      return {b, v, y, r, d, t};
   endfunction

   function automatic logic [12:0] out16();
      return {busy16, voted16, yes16, res16, done16, to16};
   endfunction

   function automatic logic [12:0] out4();
      return {busy4, voted4, yes4, res4, done4, to4};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got=%h expected=%h", nm, got, exp);
   endtask

   task automatic step(input logic r, input logic s, input logic [3:0] v, input logic [3:0] val);
      @(negedge clk);
      rst = r; start = s; vv = v; vval = val;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      // rst_start_vv_vval -> expected outputs after the edge
      tbl.push_back('{1'b1, 1'b0, 4'h0, 4'h0, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'hF, 4'hF, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'hF, 4'hB, o(1, 4'hF, 3, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'hF, 3, 3'b100, 1, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'hF, 3, 3'b100, 0, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h3, 4'h3, o(1, 4'h3, 2, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h4, 4'h0, o(1, 4'h7, 2, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h8, 4'h0, o(1, 4'hF, 2, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(0, 4'hF, 2, 3'b010, 1, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h1, 4'h1, o(1, 4'h1, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(1, 4'h1, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h1, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h1, 4'h0, o(1, 4'h1, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'hE, 4'h0, o(1, 4'hF, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'hF, 1, 3'b001, 1, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h3, 4'h1, o(1, 4'h3, 1, 3'b000, 0, 0)});
      tbl.push_back('{1'b1, 1'b1, 4'hC, 4'hC, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b1, 1'b1, 4'h0, 4'h0, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, o(1, 4'h0, 0, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'hF, 4'hF, o(1, 4'hF, 4, 3'b000, 0, 0)});
      tbl.push_back('{1'b0, 1'b0, 4'h0, 4'h0, o(0, 4'hF, 4, 3'b100, 1, 0)});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].start, tbl[i].vv, tbl[i].vval);
         chk($sformatf("row%0d", i), 32'(out16()), 32'(tbl[i].exp));
      end

      // TIMEOUT=16, only voter 2 votes yes: DECIDE entered on the 16th COLLECT edge.
      step(1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b1, 4'h0, 4'h0);
      for (int k = 1; k <= 16; k++) begin
         if (k == 1) step(1'b0, 1'b0, 4'h4, 4'h4);
         else        step(1'b0, 1'b0, 4'h0, 4'h0);
         chk($sformatf("t16_c%0d", k), 32'({busy16, done16, to16}), 32'({1'b1, 1'b0, k == 16}));
      end
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk("t16_verdict", 32'(out16()), 32'(o(0, 4'h4, 1, 3'b001, 1, 1)));

      // TIMEOUT=4, final ballot on the 4th COLLECT cycle: no timeout flag.
      step(1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b1, 4'h0, 4'h0);
      for (int k = 1; k <= 4; k++) begin
         if (k == 1)      step(1'b0, 1'b0, 4'h7, 4'h3);
         else if (k == 4) step(1'b0, 1'b0, 4'h8, 4'h8);
         else             step(1'b0, 1'b0, 4'h0, 4'h0);
         chk($sformatf("t4_last_c%0d", k), 32'({busy4, voted4, to4}),
             32'({1'b1, (k == 4) ? 4'hF : 4'h7, 1'b0}));
      end
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk("t4_last_verdict", 32'(out4()), 32'(o(0, 4'hF, 3, 3'b100, 1, 0)));

      // TIMEOUT=4 genuine timeout, opened by a start on the done cycle.
      step(1'b0, 1'b1, 4'h0, 4'h0);
      chk("t4_restart", 32'(out4()), 32'(o(1, 4'h0, 0, 3'b000, 0, 0)));
      for (int k = 1; k <= 4; k++) begin
         if (k == 1) step(1'b0, 1'b0, 4'h1, 4'h1);
         else        step(1'b0, 1'b0, 4'h0, 4'h0);
         chk($sformatf("t4_to_c%0d", k), 32'({busy4, done4, to4}), 32'({1'b1, 1'b0, k == 4}));
      end
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk("t4_to_verdict", 32'(out4()), 32'(o(0, 4'h1, 1, 3'b001, 1, 1)));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
